// File: rtl/div_iter_unit.sv
// Iterative 32-bit divider: restoring algorithm, one quotient bit per clock.
// Signed mode divides magnitudes and fixes the signs of quotient and remainder at completion.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | waiting for start_i (annul_i=1 blocks acceptance)
// DIVZERO | divisor was zero; one cycle, then END with the fixed result
// ON      | 32 restoring-division steps, counter 0..31
// END     | result_o valid, ready_o=1; held until start_i falls
module div_iter_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] rem_q, rem_d;
    logic        neg_quot_q, neg_quot_d;
    logic        neg_rem_q, neg_rem_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        step_ge;
    logic [31:0] rem_step;
    logic [31:0] quot_step;
    logic [31:0] quot_fix;
    logic [31:0] rem_fix;
    logic [31:0] abs_op1;
    logic [31:0] abs_op2;

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    always_comb begin
        shifted   = {rem_q, quot_q[31]};
        diff      = shifted - {1'b0, divisor_q};
        step_ge   = ~diff[32];
        rem_step  = step_ge ? diff[31:0] : shifted[31:0];
        quot_step = {quot_q[30:0], step_ge};
        quot_fix  = neg_quot_q ? (32'd0 - quot_step) : quot_step;
        rem_fix   = neg_rem_q  ? (32'd0 - rem_step)  : rem_step;
    end

    always_comb begin
        abs_op1 = (signed_div_i && opdata1_i[31]) ? (32'd0 - opdata1_i) : opdata1_i;
        abs_op2 = (signed_div_i && opdata2_i[31]) ? (32'd0 - opdata2_i) : opdata2_i;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        quot_d     = quot_q;
        rem_d      = rem_q;
        neg_quot_d = neg_quot_q;
        neg_rem_d  = neg_rem_q;
        result_d   = result_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i && !annul_i) begin
                    dividend_d = opdata1_i;
                    divisor_d  = abs_op2;
                    quot_d     = abs_op1;
                    rem_d      = 32'd0;
                    cnt_d      = 6'd0;
                    neg_quot_d = signed_div_i && (opdata1_i[31] ^ opdata2_i[31]);
                    neg_rem_d  = signed_div_i && opdata1_i[31];
                    state_d    = (opdata2_i == 32'd0) ? ST_DIVZERO : ST_ON;
                end
            end
            ST_DIVZERO: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    result_d = {dividend_q, 32'hFFFF_FFFF};
                    state_d  = ST_END;
                end
            end
            ST_ON: begin
                if (annul_i) begin
                    state_d = ST_IDLE;
                end else begin
                    rem_d  = rem_step;
                    quot_d = quot_step;
                    cnt_d  = cnt_q + 6'd1;
                    if (cnt_q == 6'd31) begin
                        result_d = {rem_fix, quot_fix};
                        state_d  = ST_END;
                    end
                end
            end
            ST_END: begin
                if (!start_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Flags are decoded from the next state so they come straight off flops.
        busy_d  = (state_d == ST_DIVZERO) || (state_d == ST_ON);
        ready_d = (state_d == ST_END);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 6'd0;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            quot_q     <= 32'd0;
            rem_q      <= 32'd0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            result_q   <= 64'd0;
            ready_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            quot_q     <= quot_d;
            rem_q      <= rem_d;
            neg_quot_q <= neg_quot_d;
            neg_rem_q  <= neg_rem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;
    assign busy_o   = busy_q;

endmodule

// File: tb/tb_div_iter_unit.sv
// Bench for div_iter_unit: latency-level reference model checked every cycle,
// plus directed vectors with hand-computed results.
module tb_div_iter_unit;

    logic        clk;
    logic        rst;
    logic        signed_div_i;
    logic [31:0] opdata1_i;
    logic [31:0] opdata2_i;
    logic        start_i;
    logic        annul_i;
    logic [63:0] result_o;
    logic        ready_o;
    logic        busy_o;

    int errors;
    int checks;

    div_iter_unit dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div_i),
        .opdata1_i    (opdata1_i),
        .opdata2_i    (opdata2_i),
        .start_i      (start_i),
        .annul_i      (annul_i),
        .result_o     (result_o),
        .ready_o      (ready_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference arithmetic straight from the rules: C-style truncating division.
    function automatic logic [63:0] ref_div(input bit s, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        if (b == 32'd0) return {a, 32'hFFFF_FFFF};
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q  = sa / sb;
            r  = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {a % b, a / b};
    endfunction

    // Latency model: cycles left in flight, done flag, committed result.
    int          m_left;
    bit          m_done;
    logic [63:0] m_result;
    logic [63:0] m_pending;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_left    <= 0;
            m_done    <= 1'b0;
            m_result  <= 64'd0;
            m_pending <= 64'd0;
        end else if (m_done) begin
            if (!start_i) m_done <= 1'b0;
        end else if (m_left > 0) begin
            if (annul_i) begin
                m_left <= 0;
            end else begin
                m_left <= m_left - 1;
                if (m_left == 1) begin
                    m_done   <= 1'b1;
                    m_result <= m_pending;
                end
            end
        end else if (start_i && !annul_i) begin
            m_pending <= ref_div(signed_div_i, opdata1_i, opdata2_i);
            m_left    <= (opdata2_i == 32'd0) ? 1 : 32;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            chk("cyc busy", 64'(busy_o), 64'(m_left > 0));
            chk("cyc ready", 64'(ready_o), 64'(m_done));
            chk("cyc result", result_o, m_result);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Starts a division, waits for ready, checks latency/result, then releases start.
    task automatic run_div(input string name, input bit s, input logic [31:0] a, input logic [31:0] b,
                           input int exp_edges, input logic [63:0] exp_res, input bit scramble);
        int  n;
        bit  done;
        signed_div_i = s;
        opdata1_i    = a;
        opdata2_i    = b;
        start_i      = 1'b1;
        annul_i      = 1'b0;
        n    = 0;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            tick();
            n++;
            if (scramble) begin
                opdata1_i    = $urandom;
                opdata2_i    = $urandom;
                signed_div_i = 1'($urandom_range(0, 1));
            end
            if (ready_o) done = 1'b1;
        end
        chk({name, " edges"}, 64'(n), 64'(exp_edges));
        chk({name, " result"}, result_o, exp_res);
        start_i = 1'b0;
        tick();
        chk({name, " ready drop"}, 64'(ready_o), 64'd0);
    endtask

    logic [63:0] held;

    initial begin
        errors       = 0;
        checks       = 0;
        rst          = 1'b0;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd0;
        opdata2_i    = 32'd0;
        start_i      = 1'b0;
        annul_i      = 1'b0;
        #1;
        chk("reset result", result_o, 64'd0);
        chk("reset ready", 64'(ready_o), 64'd0);
        chk("reset busy", 64'(busy_o), 64'd0);
        #21;
        rst = 1'b1;
        tick();

        // Pin the model itself against hand-computed values.
        chk("model 100/7", ref_div(1'b0, 32'd100, 32'd7), {32'd2, 32'd14});
        chk("model -7/2", ref_div(1'b1, 32'hFFFF_FFF9, 32'd2), {32'hFFFF_FFFF, 32'hFFFF_FFFD});
        chk("model min/-1", ref_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF), {32'h0, 32'h8000_0000});

        // Unsigned 100/7 with start held; END must ignore start and annul.
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        begin
            int n;
            n = 0;
            for (int i = 0; i < 40 && !ready_o; i++) begin
                tick();
                n++;
            end
            chk("100/7 edges", 64'(n), 64'd33);
            chk("100/7 result", result_o, {32'd2, 32'd14});
        end
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        tick();
        chk("END holds ready", 64'(ready_o), 64'd1);
        start_i = 1'b0;
        tick();
        chk("100/7 ready drop", 64'(ready_o), 64'd0);

        run_div("s -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);
        run_div("s min/-1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, {32'h0, 32'h8000_0000}, 1'b0);
        run_div("s -7/-2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 33, {32'hFFFF_FFFF, 32'd3}, 1'b0);
        run_div("s 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, {32'd1, 32'hFFFF_FFFD}, 1'b0);
        run_div("u max/1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, {32'd0, 32'hFFFF_FFFF}, 1'b0);
        run_div("u 3/10", 1'b0, 32'd3, 32'd10, 33, {32'd3, 32'd0}, 1'b0);
        run_div("s -5/0", 1'b1, 32'hFFFF_FFFB, 32'd0, 2, {32'hFFFF_FFFB, 32'hFFFF_FFFF}, 1'b0);
        run_div("u 5/0", 1'b0, 32'd5, 32'd0, 2, {32'd5, 32'hFFFF_FFFF}, 1'b0);

        // annul_i in IDLE blocks acceptance.
        opdata1_i = 32'd50;
        opdata2_i = 32'd5;
        start_i   = 1'b1;
        annul_i   = 1'b1;
        tick();
        chk("annul blocks start", 64'(busy_o), 64'd0);
        start_i = 1'b0;
        annul_i = 1'b0;
        tick();

        // Annul at ON cycle 10: back to IDLE, no ready, result untouched.
        held         = result_o;
        signed_div_i = 1'b0;
        opdata1_i    = 32'd100;
        opdata2_i    = 32'd7;
        start_i      = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        chk("busy before annul", 64'(busy_o), 64'd1);
        annul_i = 1'b1;
        tick();
        annul_i = 1'b0;
        chk("annul busy", 64'(busy_o), 64'd0);
        for (int i = 0; i < 30; i++) tick();
        chk("annul no ready", 64'(ready_o), 64'd0);
        chk("annul result kept", result_o, held);
        run_div("u 9/3", 1'b0, 32'd9, 32'd3, 33, {32'd0, 32'd3}, 1'b0);

        // Async reset at ON cycle 20, asserted between clock edges.
        opdata1_i = 32'd100;
        opdata2_i = 32'd7;
        start_i   = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        #1;
        rst = 1'b0;
        #1;
        chk("async rst result", result_o, 64'd0);
        chk("async rst busy", 64'(busy_o), 64'd0);
        chk("async rst ready", 64'(ready_o), 64'd0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        tick();
        run_div("u max/16", 1'b0, 32'hFFFF_FFFF, 32'h10, 33, {32'hF, 32'h0FFF_FFFF}, 1'b0);

        // Operands churn during ON; the result must come from the accepted ones.
        run_div("u 1000/13 churn", 1'b0, 32'd1000, 32'd13, 33, {32'd12, 32'd76}, 1'b1);
        run_div("s -1000/13 churn", 1'b1, 32'hFFFF_FC18, 32'd13, 33, {32'hFFFF_FFF4, 32'hFFFF_FFB4}, 1'b1);

        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
